// File: rtl/audio_echo_stage_pkg.sv
// rtl/audio_echo_stage_pkg.sv - shared sample constants, FSM states and echo arithmetic
package audio_echo_stage_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;
  localparam logic signed [AUDIO_DATA_WIDTH-1:0] SAMPLE_MAX = 24'sh7FFFFF;
  localparam logic signed [AUDIO_DATA_WIDTH-1:0] SAMPLE_MIN = 24'sh800000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Clamp a 25-bit sum back into the 24-bit sample range.
  function automatic logic signed [AUDIO_DATA_WIDTH-1:0] sat24(
    input logic signed [AUDIO_DATA_WIDTH:0] s
  );
    if (s[AUDIO_DATA_WIDTH] != s[AUDIO_DATA_WIDTH-1]) begin
      return s[AUDIO_DATA_WIDTH] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return s[AUDIO_DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [AUDIO_DATA_WIDTH-1:0] echo_mix(
    input logic signed [AUDIO_DATA_WIDTH-1:0] x,
    input logic signed [AUDIO_DATA_WIDTH-1:0] d,
    input logic        [2:0]                  shift,
    input logic                               en
  );
    logic signed [AUDIO_DATA_WIDTH:0] xx;
    logic signed [AUDIO_DATA_WIDTH:0] dd;
    logic signed [AUDIO_DATA_WIDTH:0] s;
    xx = {x[AUDIO_DATA_WIDTH-1], x};
    dd = {d[AUDIO_DATA_WIDTH-1], d};
    s  = xx + (dd >>> shift);
    return en ? sat24(s) : x;
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// rtl/echo_delay_ram.sv - simple dual-port delay RAM, one write port and one registered read port
module echo_delay_ram #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array so it maps onto block RAM; the owner clears it explicitly.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_echo_stage.sv
// rtl/audio_echo_stage.sv - stereo echo stage: y = sat(x + (y[n-DEPTH] >>> decay_shift))
module audio_echo_stage
  import audio_echo_stage_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [2:0]                  decay_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [AUDIO_DATA_WIDTH-1:0] in_left,
  input  logic [AUDIO_DATA_WIDTH-1:0] in_right,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AUDIO_DATA_WIDTH-1:0] out_left,
  output logic [AUDIO_DATA_WIDTH-1:0] out_right
);

  localparam int W = AUDIO_DATA_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_left_q, out_left_d;
  logic [W-1:0]      out_right_q, out_right_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [2*W-1:0]    ram_wdata;
  logic [2*W-1:0]    ram_rdata;
  logic [W-1:0]      y_left, y_right;
  logic              accept, xfer;

  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  assign y_left  = echo_mix(in_left,  ram_rdata[2*W-1:W], decay_shift, enable);
  assign y_right = echo_mix(in_right, ram_rdata[W-1:0],   decay_shift, enable);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    ram_we      = 1'b0;
    ram_waddr   = ptr_q;
    ram_wdata   = {y_left, y_right};

    case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          // Bypass still writes y (= x) so the echo resumes seamlessly when re-enabled.
          ram_we      = 1'b1;
          out_valid_d = 1'b1;
          out_left_d  = y_left;
          out_right_d = y_right;
          ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
    end
  end

  // Reading at ptr_d keeps the registered read data aligned with ptr_q on the next accept.
  echo_delay_ram #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ptr_d),
    .rdata_o(ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;

endmodule

// File: tb/tb_audio_echo_stage.sv
// tb/tb_audio_echo_stage.sv - randomized and directed checks of audio_echo_stage against a sample-level model
module tb_audio_echo_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic [2:0]  decay_shift = 3'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_left;
  logic [23:0] out_right;

  int errors = 0;
  int checks = 0;

  int mbuf_l [DEPTH];
  int mbuf_r [DEPTH];
  int mptr = 0;

  always #5 clk = ~clk;

  audio_echo_stage #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .decay_shift(decay_shift),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_left   (out_left),
    .out_right  (out_right)
  );

  function automatic int ref_y(input int x, input int d, input bit e, input int s);
    int v;
    if (!e) return x;
    v = x + (d >>> s);
    if (v > 8388607) v = 8388607;
    else if (v < -8388608) v = -8388608;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mbuf_l[i] = 0;
      mbuf_r[i] = 0;
    end
    mptr = 0;
  endtask

  task automatic model_accept(input int l, input int r, output int el, output int er);
    el = ref_y(l, mbuf_l[mptr], enable, int'(decay_shift));
    er = ref_y(r, mbuf_r[mptr], enable, int'(decay_shift));
    mbuf_l[mptr] = el;
    mbuf_r[mptr] = er;
    mptr = (mptr + 1) % DEPTH;
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    resetn = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL reset_ready_timeout in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic push(input int l, input int r, output int ol, output int orr);
    int n;
    int el, er;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_left  = l[23:0];
    in_right = r[23:0];
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=%0b expected 1", in_ready);
    end
    model_accept(l, r, el, er);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ol  = int'($signed(out_left));
    orr = int'($signed(out_right));
  endtask

  task automatic check_clear_window(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_clear_cycle%0d in_ready=%0b expected 0", tag, k, in_ready);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_run_ready in_ready=%0b expected 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_left !== 24'd0 || out_right !== 24'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out_valid=%0b out_left=%0d out_right=%0d in_ready=%0b expected 0 0 0 0",
               out_valid, out_left, out_right, in_ready);
    end
    resetn = 1'b1;
    model_reset();
    check_clear_window("reset");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_impulse();
    int stim [9] = '{1000, 0, 0, 0, 0, 0, 0, 0, 0};
    int expl [9] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250};
    int ol, orr;
    do_reset();
    enable = 1'b1;
    decay_shift = 3'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(stim[i], 0, ol, orr);
      checks++;
      if (ol !== expl[i] || orr !== 0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL impulse[%0d] got L=%0d R=%0d v=%0b expected L=%0d R=0 v=1", i, ol, orr, out_valid, expl[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int ol, orr, el, er;
    do_reset();
    enable = 1'b1;
    decay_shift = 3'd0;
    for (int i = 0; i < 5; i++) begin
      push(8000000, -8000000, ol, orr);
      el = (i < 4) ? 8000000 : 8388607;
      er = (i < 4) ? -8000000 : -8388608;
      checks++;
      if (ol !== el || orr !== er) begin
        errors++;
        $display("FAIL saturation[%0d] got L=%0d R=%0d expected L=%0d R=%0d", i, ol, orr, el, er);
      end
    end
  endtask

  task automatic test_backpressure();
    int ea_l, ea_r, eb_l, eb_r;
    do_reset();
    enable = 1'b1;
    decay_shift = 3'd2;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_left = 24'd1111;
    in_right = -24'sd2222;
    model_accept(1111, -2222, ea_l, ea_r);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || int'($signed(out_left)) !== ea_l || int'($signed(out_right)) !== ea_r) begin
      errors++;
      $display("FAIL bp_capture got v=%0b L=%0d R=%0d expected v=1 L=%0d R=%0d",
               out_valid, $signed(out_left), $signed(out_right), ea_l, ea_r);
    end
    in_left = 24'd3333;
    in_right = -24'sd4444;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || int'($signed(out_left)) !== ea_l ||
          int'($signed(out_right)) !== ea_r) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%0b v=%0b L=%0d R=%0d expected rdy=0 v=1 L=%0d R=%0d",
                 k, in_ready, out_valid, $signed(out_left), $signed(out_right), ea_l, ea_r);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready in_ready=%0b expected 1", in_ready);
    end
    model_accept(3333, -4444, eb_l, eb_r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || int'($signed(out_left)) !== eb_l || int'($signed(out_right)) !== eb_r) begin
      errors++;
      $display("FAIL bp_swap got v=%0b L=%0d R=%0d expected v=1 L=%0d R=%0d",
               out_valid, $signed(out_left), $signed(out_right), eb_l, eb_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_bypass();
    int ol, orr;
    do_reset();
    out_ready = 1'b1;
    enable = 1'b0;
    decay_shift = 3'd3;
    for (int i = 1; i <= 4; i++) begin
      push(100 * i, -100 * i, ol, orr);
      checks++;
      if (ol !== 100 * i || orr !== -100 * i) begin
        errors++;
        $display("FAIL bypass[%0d] got L=%0d R=%0d expected L=%0d R=%0d", i, ol, orr, 100 * i, -100 * i);
      end
    end
    enable = 1'b1;
    decay_shift = 3'd0;
    push(0, 0, ol, orr);
    checks++;
    if (ol !== 100 || orr !== -100) begin
      errors++;
      $display("FAIL bypass_resume got L=%0d R=%0d expected L=100 R=-100", ol, orr);
    end
  endtask

  task automatic test_midrun_reset();
    int stim [5] = '{1000, 0, 0, 0, 0};
    int expl [5] = '{1000, 0, 0, 0, 500};
    int ol, orr;
    do_reset();
    enable = 1'b1;
    decay_shift = 3'd1;
    out_ready = 1'b1;
    push(5000, 7000, ol, orr);
    push(6000, 8000, ol, orr);
    push(7000, 9000, ol, orr);
    out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_discard out_valid=%0b expected 0", out_valid);
    end
    resetn = 1'b1;
    out_ready = 1'b1;
    model_reset();
    check_clear_window("midrun");
    for (int i = 0; i < 5; i++) begin
      push(stim[i], stim[i], ol, orr);
      checks++;
      if (ol !== expl[i] || orr !== expl[i]) begin
        errors++;
        $display("FAIL midrun_impulse[%0d] got L=%0d R=%0d expected %0d", i, ol, orr, expl[i]);
      end
    end
  endtask

  task automatic test_random();
    int ql [$];
    int qr [$];
    int el, er, l, r;
    bit acc, xf;
    do_reset();
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        in_left     = 24'($urandom());
        in_right    = 24'($urandom());
        enable      = ($urandom_range(0, 4) != 0);
        decay_shift = 3'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (out_valid !== (ql.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid[%0d] out_valid=%0b expected %0b", c, out_valid, ql.size() != 0);
      end
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf && ql.size() != 0) begin
        el = ql.pop_front();
        er = qr.pop_front();
        checks++;
        if (int'($signed(out_left)) !== el || int'($signed(out_right)) !== er) begin
          errors++;
          $display("FAIL rand_data[%0d] got L=%0d R=%0d expected L=%0d R=%0d",
                   c, $signed(out_left), $signed(out_right), el, er);
        end
      end
      if (acc) begin
        l = int'($signed(in_left));
        r = int'($signed(in_right));
        model_accept(l, r, el, er);
        ql.push_back(el);
        qr.push_back(er);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4 && ql.size() != 0; k++) begin
      #1;
      if (out_valid) begin
        el = ql.pop_front();
        er = qr.pop_front();
        checks++;
        if (int'($signed(out_left)) !== el || int'($signed(out_right)) !== er) begin
          errors++;
          $display("FAIL rand_drain got L=%0d R=%0d expected L=%0d R=%0d",
                   $signed(out_left), $signed(out_right), el, er);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ql.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover pending=%0d expected 0", ql.size());
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_bypass();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
